// File: rtl/stereo_sample_queue_if.sv
// Sample-in / burst-out bundle between codec_intf, stereo_sample_queue and the filter datapath.
// The master side is the codec that produces samples. The slave side is the queue.
interface stereo_sample_queue_if #(
  parameter int DATA_W = 16
);
  logic              valid;
  logic [DATA_W-1:0] lft_in;
  logic [DATA_W-1:0] rht_in;
  logic [DATA_W-1:0] lft_smpl;
  logic [DATA_W-1:0] rht_smpl;
  logic              sequencing;
  logic              full;
  logic              overrun;

  modport master (
    output valid, lft_in, rht_in,
    input  lft_smpl, rht_smpl, sequencing, full, overrun
  );

  modport slave (
    input  valid, lft_in, rht_in,
    output lft_smpl, rht_smpl, sequencing, full, overrun
  );
endinterface

// File: rtl/stereo_sample_queue.sv
// Circular stereo buffer that keeps the last DEPTH pairs. Once it is full, every new pair
// streams the whole window, oldest first. Optional STEREO_QUEUE_OVERRUN_EN adds sticky overrun.
module stereo_sample_queue #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  stereo_sample_queue_if.slave bus
);

  typedef enum logic [1:0] {S_FILL, S_WAIT, S_SEQ} state_t;

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] RD_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                full_q, full_d;
  logic                rd_vld_q, rd_vld_d;
  logic                sequencing_q, sequencing_d;
  logic [DATA_W-1:0]   lft_smpl_q, lft_smpl_d;
  logic [DATA_W-1:0]   rht_smpl_q, rht_smpl_d;
  logic [2*DATA_W-1:0] rd_data_q;
  logic                rd_en;

  logic [2*DATA_W-1:0] mem [DEPTH];

  // NOTE: The sample array has no reset, so it maps onto plain RAM. The pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (bus.valid) mem[wptr_q] <= {bus.lft_in, bus.rht_in};
    if (rd_en)     rd_data_q   <= mem[rptr_q];
  end

  // NOTE: Every signal gets its default at the top of the block. This keeps any path from leaving a value unassigned, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    rd_cnt_d     = rd_cnt_q;
    cnt_d        = cnt_q;
    full_d       = full_q;
    rd_vld_d     = 1'b0;
    sequencing_d = rd_vld_q;
    lft_smpl_d   = lft_smpl_q;
    rht_smpl_d   = rht_smpl_q;
    rd_en        = (state_q == S_SEQ);

    if (rd_vld_q) {lft_smpl_d, rht_smpl_d} = rd_data_q;

    if (bus.valid) begin
      wptr_d = wptr_q + PTR_ONE;
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
    end

    // A burst always restarts from the slot after the pair just written, which is the oldest entry.
    unique case (state_q)
      S_FILL: begin
        if (bus.valid && cnt_q == CNT_LAST) begin
          full_d   = 1'b1;
          state_d  = S_SEQ;
          rptr_d   = wptr_q + PTR_ONE;
          rd_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (bus.valid) begin
          state_d  = S_SEQ;
          rptr_d   = wptr_q + PTR_ONE;
          rd_cnt_d = '0;
        end
      end
      S_SEQ: begin
        rd_vld_d = 1'b1;
        rptr_d   = rptr_q + PTR_ONE;
        rd_cnt_d = rd_cnt_q + PTR_ONE;
        if (rd_cnt_q == RD_LAST) begin
          if (bus.valid) begin
            rptr_d   = wptr_q + PTR_ONE;
            rd_cnt_d = '0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FILL;
      wptr_q       <= '0;
      rptr_q       <= '0;
      rd_cnt_q     <= '0;
      cnt_q        <= '0;
      full_q       <= 1'b0;
      rd_vld_q     <= 1'b0;
      sequencing_q <= 1'b0;
      lft_smpl_q   <= '0;
      rht_smpl_q   <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      rd_cnt_q     <= rd_cnt_d;
      cnt_q        <= cnt_d;
      full_q       <= full_d;
      rd_vld_q     <= rd_vld_d;
      sequencing_q <= sequencing_d;
      lft_smpl_q   <= lft_smpl_d;
      rht_smpl_q   <= rht_smpl_d;
    end
  end

`ifdef STEREO_QUEUE_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (bus.valid && state_q == S_SEQ) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  assign bus.overrun = overrun_q;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.lft_smpl   = lft_smpl_q;
  assign bus.rht_smpl   = rht_smpl_q;
  assign bus.sequencing = sequencing_q;
  assign bus.full       = full_q;

endmodule
